// File: rtl/bf16_dot_seq_if.sv
// Operand stream, MAC datapath link and result stream of the bf16 dot-product sequencer.
// slave = the sequencer itself, master = its surroundings (fetch, MAC, writeback).
interface bf16_dot_seq_if;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [31:0] mac_c;
    logic [31:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    modport slave (
        input  op_valid, op_a, op_b, mac_out, res_ready,
        output op_ready, mac_a, mac_b, mac_c, res_valid, res_data
    );

    modport master (
        output op_valid, op_a, op_b, mac_out, res_ready,
        input  op_ready, mac_a, mac_b, mac_c, res_valid, res_data
    );
endinterface

// File: rtl/bf16_dot_seq.sv
// Sequencer for one bf16 dot product plus fp32 bias on an external combinational MAC.
// Optional DOT_ZERO_SKIP_EN: pairs with a +/-0 operand leave acc untouched and are counted in o_skip_cnt.
module bf16_dot_seq #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [31:0]      i_bias,
    output logic             o_busy,
`ifdef DOT_ZERO_SKIP_EN
    output logic [LEN_W-1:0] o_skip_cnt,
`endif
    bf16_dot_seq_if.slave    io_bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_op_ready;
    logic             r_res_valid;
    logic             r_busy;
    logic             w_xfer;
    logic [31:0]      w_acc_next;

    assign io_bus.mac_a    = io_bus.op_a;
    assign io_bus.mac_b    = io_bus.op_b;
    assign io_bus.mac_c    = r_acc;
    assign io_bus.res_data = r_acc;
    assign io_bus.op_ready = r_op_ready;
    assign io_bus.res_valid = r_res_valid;
    assign o_busy          = r_busy;

    assign w_xfer = r_op_ready && io_bus.op_valid;

`ifdef DOT_ZERO_SKIP_EN
    logic             w_skip;
    logic [LEN_W-1:0] r_skip_cnt;

    assign w_skip     = (io_bus.op_a[14:0] == 15'd0) || (io_bus.op_b[14:0] == 15'd0);
    assign w_acc_next = w_skip ? r_acc : io_bus.mac_out;
    assign o_skip_cnt = r_skip_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_cnt <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_skip_cnt <= '0;
        end else if (r_state == S_RUN && w_xfer && w_skip) begin
            r_skip_cnt <= r_skip_cnt + LEN_W'(1);
        end
    end
`else
    assign w_acc_next = io_bus.mac_out;
`endif

    // NOTE: all state, including the handshake outputs, updates with <= so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc  <= i_bias;
                        r_cnt  <= i_len;
                        r_busy <= 1'b1;
                        if (i_len != '0) begin
                            r_state    <= S_RUN;
                            r_op_ready <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state     <= S_DONE;
                            r_op_ready  <= 1'b0;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (io_bus.res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_op_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_dot_seq.sv
// Self-checking bench for bf16_dot_seq: directed and random dot-product jobs against a real-arithmetic model.
// Build with or without DOT_ZERO_SKIP_EN; the model follows the same macro.
module tb_bf16_dot_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [31:0] bias;
    logic        busy;
`ifdef DOT_ZERO_SKIP_EN
    logic [15:0] skip_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    bf16_dot_seq_if bus ();

    bf16_dot_seq #(.LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_len      (len),
        .i_bias     (bias),
        .o_busy     (busy),
`ifdef DOT_ZERO_SKIP_EN
        .o_skip_cnt (skip_cnt),
`endif
        .io_bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic real f32_to_real(logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i > e; i--) m = m / 2.0;
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_f32(real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] mr;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e  = int'(d[62:52]) - 1023 + 127;
        m  = {1'b1, d[51:0]};
        mr = {1'b0, m[52:29]};
        if (m[28] && ((|m[27:0]) || m[29])) mr = mr + 25'd1;
        if (mr[24]) begin
            mr = mr >> 1;
            e++;
        end
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], 8'(e), mr[22:0]};
    endfunction

    // bf16 x bf16 products are exact in double; the sum is rounded once to fp32.
    function automatic logic [31:0] mac_ref(logic [15:0] a, logic [15:0] b, logic [31:0] c);
        return real_to_f32(f32_to_real({a, 16'h0}) * f32_to_real({b, 16'h0}) + f32_to_real(c));
    endfunction

    always_comb bus.mac_out = mac_ref(bus.mac_a, bus.mac_b, bus.mac_c);

    function automatic logic [15:0] rand_bf16();
        logic s;
        s = 1'($urandom_range(1, 0));
        if ($urandom_range(7, 0) == 0) return {s, 15'd0};
        return {s, 8'($urandom_range(134, 120)), 7'($urandom_range(127, 0))};
    endfunction

    function automatic logic [31:0] rand_f32();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int n);
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(rand_bf16());
            qb.push_back(rand_bf16());
        end
    endtask

    // Runs one job from a negedge: pairs from qa/qb, optional bubbles, result stall, mid-run start poke.
    task automatic run_job(input string tag, input int n, input logic [31:0] b,
                           input bit bubbles, input int stall, input bit poke,
                           output logic [31:0] result);
        logic [31:0] exp_acc;
        int          exp_skip;
        int          idx;
        int          cyc;
        bit          vld;
        exp_acc  = b;
        exp_skip = 0;
        for (int i = 0; i < n; i++) begin
`ifdef DOT_ZERO_SKIP_EN
            if (qa[i][14:0] == 15'd0 || qb[i][14:0] == 15'd0) begin
                exp_skip++;
                continue;
            end
`endif
            exp_acc = mac_ref(qa[i], qb[i], exp_acc);
        end

        start = 1'b1;
        len   = 16'(n);
        bias  = b;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (n == 0) check({tag, "_no_ready"}, 32'(bus.op_ready), 32'd0);

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 4 * n + 20) begin
            vld          = bubbles ? (cyc % 2 == 0) : 1'b1;
            bus.op_valid = vld;
            bus.op_a     = qa[idx];
            bus.op_b     = qb[idx];
            if (poke && cyc == 1) begin
                start = 1'b1;
                len   = 16'd5;
                bias  = 32'h4120_0000;
            end else begin
                start = 1'b0;
            end
            if (vld && bus.op_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.op_valid = 1'b0;
        start        = 1'b0;
        check({tag, "_xfers"}, 32'(idx), 32'(n));

        for (int s = 0; s < stall; s++) begin
            check({tag, "_valid_hold"}, 32'(bus.res_valid), 32'd1);
            check({tag, "_data_hold"}, bus.res_data, exp_acc);
            check({tag, "_ready_low"}, 32'(bus.op_ready), 32'd0);
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_data"}, bus.res_data, exp_acc);
`ifdef DOT_ZERO_SKIP_EN
        check({tag, "_skip"}, 32'(skip_cnt), 32'(exp_skip));
`endif
        result        = bus.res_data;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        rst           = 1'b1;
        start         = 1'b0;
        len           = '0;
        bias          = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_ready", 32'(bus.op_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);

        // Basic job: 1*2 + 2*2 + 0 = 6.0
        qa = '{16'h3F80, 16'h4000};
        qb = '{16'h4000, 16'h4000};
        run_job("basic", 2, 32'h0, 1'b0, 0, 1'b0, r);
        check("basic_const", r, 32'h40C0_0000);

        // Zero length returns the bias one cycle after start.
        qa.delete();
        qb.delete();
        run_job("zero_len", 0, 32'h3F80_0000, 1'b0, 0, 1'b0, r);
        check("zero_len_const", r, 32'h3F80_0000);

        // Bubbles on the operand side and a 5-cycle result stall.
        fill_random(4);
        run_job("bubbles", 4, rand_f32(), 1'b1, 5, 1'b0, r);

        // Reset in the middle of a len=8 job.
        fill_random(8);
        start = 1'b1;
        len   = 16'd8;
        bias  = rand_f32();
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a     = qa[i];
            bus.op_b     = qb[i];
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_op_ready", 32'(bus.op_ready), 32'd0);
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_res_data", bus.res_data, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_no_result", 32'(bus.res_valid), 32'd0);
        qa = '{16'h3F80};
        qb = '{16'h3F80};
        run_job("after_rst", 1, 32'h0, 1'b0, 0, 1'b0, r);
        check("after_rst_const", r, 32'h3F80_0000);

        // A start pulse during RUN must not reload len or bias.
        fill_random(3);
        run_job("start_ignored", 3, rand_f32(), 1'b0, 1, 1'b1, r);

        // Signed zeros among the pairs: 1 + (0*2) + (1*1) + (-0*1) = 2.0 either way.
        qa = '{16'h0000, 16'h3F80, 16'h8000};
        qb = '{16'h4000, 16'h3F80, 16'h3F80};
        run_job("zero_pairs", 3, 32'h3F80_0000, 1'b0, 0, 1'b0, r);
        check("zero_pairs_const", r, 32'h4000_0000);

        // Random jobs of varying length, bubbles and stalls.
        for (int j = 0; j < 6; j++) begin
            int n;
            n = int'($urandom_range(12, 1));
            fill_random(n);
            run_job($sformatf("rand%0d", j), n, rand_f32(), 1'($urandom_range(1, 0)),
                    int'($urandom_range(3, 0)), 1'b0, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bf16_dot_seq.md
Name: bf16_dot_seq

Overview:
- Sequencer that drives the bf16 x bf16 + fp32 multiply-accumulate datapath to compute one dot product of LEN operand pairs plus an fp32 bias.
- Owns the fp32 accumulator register and the element counter. Handshakes operand pairs in and the result out.
- Sits between the operand fetch stream and the result writeback in the compute tile. The MAC datapath is an external, purely combinational unit connected through the mac_* ports.

Parameters:
- LEN_W, 16, width of the element-count field; max dot length 2^LEN_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- bias  in  32  fp32 initial accumulator value; sampled with start.
- busy  out  1  high in any state other than IDLE.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer accepts operand pair.
- op_a  in  16  bf16 operand A.
- op_b  in  16  bf16 operand B.
- mac_a  out  16  to MAC datapath, operand A.
- mac_b  out  16  to MAC datapath, operand B.
- mac_c  out  32  to MAC datapath, accumulator input.
- mac_out  in  32  from MAC datapath, combinational result of mac_a*mac_b+mac_c.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  fp32 dot-product result.

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-job):
  - state=IDLE; acc=0; cnt=0.
  - op_ready=0, res_valid=0, busy=0, res_data=0.
  - A partially computed job is discarded; no result is produced.
- Datapath wiring:
  - mac_a=op_a, mac_b=op_b, mac_c=acc, all combinational pass-through.
  - res_data=acc.
- States:
  - IDLE: op_ready=0, res_valid=0. On start:
    - acc<=bias, cnt<=len.
    - Go to RUN if len!=0, else to DONE.
    - start is ignored in all other states.
  - RUN: op_ready=1, res_valid=0.
    - A transfer occurs when op_valid&&op_ready: acc<=mac_out, cnt<=cnt-1.
    - If cnt==1 at that transfer, go to DONE next cycle.
    - No transfer: state, acc and cnt hold.
  - DONE: op_ready=0, res_valid=1, res_data=acc.
    - Holds until res_valid&&res_ready, then returns to IDLE; acc is held.
    - res_data is stable while res_valid=1 and res_ready=0.
- Throughput: one pair per cycle in RUN. Latency from the final accepted pair to res_valid=1 is 1 cycle. Back-to-back jobs need 1 IDLE cycle between result handoff and the next start.
- len=0: the result equals bias, res_valid asserted 1 cycle after start.
- Arithmetic is entirely in the external MAC. The sequencer never modifies acc except by loading bias or mac_out.
- cnt never wraps; it is decremented only in RUN with cnt>=1.
- Operand beats presented while op_ready=0 are not consumed and must be held by the source.

Optional Feature:
- Macro: DOT_ZERO_SKIP_EN.
- Defined:
  - In RUN, a pair whose op_a[14:0]==0 or op_b[14:0]==0 (±0) is still accepted and still decrements cnt.
  - acc holds its value instead of loading mac_out.
  - An extra output skip_cnt (LEN_W bits) counts skipped pairs in the current job. It is cleared on start and on reset, and is valid alongside res_valid.
- Undefined: every accepted pair loads mac_out; no skip_cnt port.

Test Plan:
- Basic job: reset, start with len=2, bias=0x00000000; pairs (0x3F80,0x4000), then (0x4000,0x4000); behavioural MAC model -> res_valid 1 cycle after the 2nd transfer, res_data=0x40C00000 (6.0).
- Zero length: start with len=0, bias=0x3F800000 -> no op_ready pulse; res_valid on the next cycle with res_data=0x3F800000.
- Backpressure and bubbles:
  - len=4, op_valid toggled 1,0,1,0...; res_ready held 0 for 5 cycles -> exactly 4 transfers.
  - res_data is stable and res_valid stays high until res_ready=1, then IDLE next cycle.
- Reset mid-job: len=8, assert rst after 3 transfers -> next cycle busy=0, op_ready=0, res_valid=0. A new job with len=1, bias=0, pair (0x3F80,0x3F80) yields 0x3F800000.
- Start ignored while busy: pulse start with len=5 during RUN of a len=3 job -> result after exactly 3 transfers; cnt is not reloaded.
- DOT_ZERO_SKIP_EN: len=3, bias=0x3F800000; pairs (0x0000,0x4000), (0x3F80,0x3F80), (0x8000,0x3F80) -> res_data=0x40000000, skip_cnt=2. With the macro undefined, the same stimulus gives res_data equal to the MAC model result.
